// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key click decoder.
//   state_t       : FSM state encoding (1 bit, IDLE/WAIT only)
//   evt_t         : event codes, also intended for a future encoded event bus
//   WIN_MAX_50MHZ : last timer value of a 250 ms window at 50 MHz
//   evt_for_count : maps a closed group's press count to its event code
// -----------------------------------------------------------------------------
package key_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        EVT_NONE   = 2'd0,
        EVT_SINGLE = 2'd1,
        EVT_DOUBLE = 2'd2,
        EVT_TRIPLE = 2'd3
    } evt_t;

    localparam logic [23:0] WIN_MAX_50MHZ = 24'd12_499_999;

    function automatic evt_t evt_for_count(input logic [1:0] cnt);
        evt_t e;
        case (cnt)
            2'd1:    e = EVT_SINGLE;
            2'd2:    e = EVT_DOUBLE;
            2'd3:    e = EVT_TRIPLE;
            default: e = EVT_NONE;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/key_click_decoder.sv
// -----------------------------------------------------------------------------
// key_click_decoder
// Groups debounced key presses that fall within a programmable window and
// classifies each group as a single, double or triple click.
//
// Ports:
//   sys_clk      in   system clock (50 MHz)
//   sys_rst      in   synchronous active-high reset
//   key_flag     in   one-cycle pulse per debounced press
//   single_click out  one-cycle pulse, group of exactly 1 press
//   double_click out  one-cycle pulse, group of exactly 2 presses
//   triple_click out  one-cycle pulse, group of 3 presses (emitted at once)
//   click_cnt    out  presses accumulated in the open group (0 when idle)
//   busy         out  high while a group is open
//   evt_total    out  wrapping count of emitted events
// -----------------------------------------------------------------------------
module key_click_decoder
    import key_pkg::*;
#(
    parameter int unsigned      CNT_W   = 24,
    parameter logic [CNT_W-1:0] WIN_MAX = CNT_W'(WIN_MAX_50MHZ)
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key_flag,
    output logic       single_click,
    output logic       double_click,
    output logic       triple_click,
    output logic [1:0] click_cnt,
    output logic       busy,
    output logic [7:0] evt_total
);

    state_t           state;
    logic [CNT_W-1:0] timer;
    evt_t             next_evt;

    // Event decided from pre-edge values. A press arriving while the timer
    // sits at WIN_MAX takes priority over window expiry, so it counts.
    always_comb begin
        next_evt = EVT_NONE;
        if (state == ST_WAIT) begin
            if (key_flag) begin
                if (click_cnt == 2'd2) begin
                    next_evt = EVT_TRIPLE;
                end
            end else if (timer == WIN_MAX) begin
                next_evt = evt_for_count(click_cnt);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= ST_IDLE;
            timer        <= '0;
            click_cnt    <= '0;
            evt_total    <= '0;
            single_click <= 1'b0;
            double_click <= 1'b0;
            triple_click <= 1'b0;
        end else begin
            single_click <= (next_evt == EVT_SINGLE);
            double_click <= (next_evt == EVT_DOUBLE);
            triple_click <= (next_evt == EVT_TRIPLE);

            if (next_evt != EVT_NONE) begin
                // Group closes; a press in the following cycle opens a new one.
                state     <= ST_IDLE;
                click_cnt <= '0;
                evt_total <= evt_total + 8'd1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (key_flag) begin
                            state     <= ST_WAIT;
                            click_cnt <= 2'd1;
                            timer     <= '0;
                        end
                    end
                    ST_WAIT: begin
                        if (key_flag) begin
                            // Second press: window restarts from zero.
                            click_cnt <= click_cnt + 2'd1;
                            timer     <= '0;
                        end else begin
                            // Never passes WIN_MAX: expiry closes the group.
                            timer <= timer + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy = (state == ST_WAIT);

endmodule

// File: tb/tb_key_click_decoder.sv
// -----------------------------------------------------------------------------
// tb_key_click_decoder
// Scoreboard bench for key_click_decoder with a 10-cycle window (WIN_MAX=9).
// Expected events (kind, edge, running total) are queued when presses are
// driven and matched against pulses observed on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_key_click_decoder;

    logic       clk;
    logic       rst;
    logic       kf;
    logic       single_click;
    logic       double_click;
    logic       triple_click;
    logic [1:0] click_cnt;
    logic       busy;
    logic [7:0] evt_total;

    typedef struct {
        int kind;   // 1 single, 2 double, 3 triple
        int due;    // edge number after which the pulse is visible
        int total;  // evt_total expected alongside the pulse
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   edge_n  = 0;
    int   exp_total = 0;

    key_click_decoder #(
        .CNT_W   (24),
        .WIN_MAX (24'd9)
    ) dut (
        .sys_clk      (clk),
        .sys_rst      (rst),
        .key_flag     (kf),
        .single_click (single_click),
        .double_click (double_click),
        .triple_click (triple_click),
        .click_cnt    (click_cnt),
        .busy         (busy),
        .evt_total    (evt_total)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic push_evt(input int kind, input int due);
        exp_t e;
        exp_total = (exp_total + 1) % 256;
        e.kind  = kind;
        e.due   = due;
        e.total = exp_total;
        q.push_back(e);
    endtask

    // One clock: inputs change on the falling edge, return just after rising.
    task automatic drive_cycle(input logic f, input logic r);
        @(negedge clk);
        kf  = f;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    // len edges; presses at relative edges f0/f1/f2, reset at rst_e (-1 = none).
    task automatic play(input int len, input int f0, input int f1, input int f2,
                        input int rst_e);
        for (int k = 0; k < len; k++) begin
            drive_cycle((k == f0) || (k == f1) || (k == f2), (k == rst_e));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_single"}, int'(single_click), 0);
        check({tag, "_double"}, int'(double_click), 0);
        check({tag, "_triple"}, int'(triple_click), 0);
        check({tag, "_cnt"},    int'(click_cnt), 0);
        check({tag, "_busy"},   int'(busy), 0);
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        int np;
        int kind;
        exp_t e;
        while (q.size() > 0 && q[0].due < edge_n) begin
            check("missed_evt", edge_n, q[0].due);
            void'(q.pop_front());
        end
        np   = int'(single_click) + int'(double_click) + int'(triple_click);
        kind = single_click ? 1 : double_click ? 2 : triple_click ? 3 : 0;
        if (np != 0) begin
            if (q.size() == 0) begin
                check("spurious_evt", kind, 0);
            end else begin
                e = q.pop_front();
                check("evt_kind",  kind, e.kind);
                check("evt_edge",  edge_n, e.due);
                check("evt_total", int'(evt_total), e.total);
                check("evt_onehot", np, 1);
            end
        end
    end

    initial begin
        int b;
        rst = 1'b1;
        kf  = 1'b0;

        // Reset, including a press that reset must override.
        drive_cycle(1'b0, 1'b1);
        drive_cycle(1'b1, 1'b1);
        check_idle_outputs("rst");
        check("rst_total", int'(evt_total), 0);
        exp_total = 0;

        // Single press: pulse after edge 10.
        b = edge_n + 1;
        push_evt(1, b + 10);
        play(5, 0, -1, -1, -1);
        check("single_busy_mid", int'(busy), 1);
        check("single_cnt_mid",  int'(click_cnt), 1);
        play(9, -1, -1, -1, -1);
        check_idle_outputs("single_after");
        check("single_total", int'(evt_total), 1);

        // Double press at 0 and 5: pulse after edge 15.
        b = edge_n + 1;
        push_evt(2, b + 15);
        play(6, 0, 5, -1, -1);
        check("double_cnt_5",  int'(click_cnt), 2);
        check("double_busy_5", int'(busy), 1);
        play(14, -1, -1, -1, -1);
        check_idle_outputs("double_after");

        // Triple press at 0, 3, 6: immediate pulse after edge 6.
        b = edge_n + 1;
        push_evt(3, b + 6);
        play(7, 0, 3, 6, -1);
        check("triple_busy", int'(busy), 0);
        check("triple_cnt",  int'(click_cnt), 0);
        play(15, -1, -1, -1, -1);

        // Press coincident with timer==WIN_MAX counts in-window.
        b = edge_n + 1;
        push_evt(2, b + 20);
        play(24, 0, 10, -1, -1);

        // Press one edge late (during the emit cycle) starts a new group.
        b = edge_n + 1;
        push_evt(1, b + 10);
        push_evt(1, b + 21);
        play(25, 0, 11, -1, -1);
        check("late_total", int'(evt_total), exp_total);

        // Reset mid-group discards it; a later press starts afresh.
        b = edge_n + 1;
        play(5, 0, -1, -1, 4);
        check_idle_outputs("midrst");
        check("midrst_total", int'(evt_total), 0);
        exp_total = 0;
        push_evt(1, b + 16);
        play(15, 1, -1, -1, -1);
        check("midrst_new_total", int'(evt_total), 1);

        // 256 single groups from zero: counter wraps back to 0.
        play(1, -1, -1, -1, 0);
        exp_total = 0;
        check("wrap_start", int'(evt_total), 0);
        for (int g = 0; g < 256; g++) begin
            b = edge_n + 1;
            push_evt(1, b + 10);
            play(12, 0, -1, -1, -1);
            if (g == 254) check("wrap_255", int'(evt_total), 255);
        end
        check("wrap_end", int'(evt_total), 0);

        // Drain: nothing may remain outstanding.
        play(15, -1, -1, -1, -1);
        check("drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
